div_result_bcd: RTL and testbench
=================================

Name: div_result_bcd

Overview:
- Downstream stage of the signed 16-bit divider.
- Captures a quotient/remainder pair on a start strobe and flags divide-by-zero and overflow.
- Converts each value to sign plus 5 packed BCD digits using iterative shift-add-3 (double dabble), one bit per cycle.
- Feeds the display/readout logic with a one-cycle done pulse.

Parameters:
- WIDTH, 16, operand width; fixed at 16 for this design.
- DIGITS, 5, BCD digits per value; 5 digits cover a magnitude of 32768.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  capture request; sampled only while busy=0
- dina  input  16  signed dividend that was presented to the divider; used for the overflow check
- dinb  input  16  signed divisor that was presented to the divider; used for the zero/overflow check
- quot  input  16  signed quotient from the divider
- rem  input  16  signed remainder from the divider
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse; result outputs valid and updated on the same edge
- err  output  1  last result was invalid (divide-by-zero or overflow)
- q_neg  output  1  quotient sign
- q_bcd  output  20  quotient magnitude; digit 4 in [19:16] down to digit 0 in [3:0]
- r_neg  output  1  remainder sign
- r_bcd  output  20  remainder magnitude; same digit layout as q_bcd

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values: all outputs 0, FSM in IDLE, internal shift and BCD registers 0.
- Reset has priority over every other event. A reset mid-conversion abandons the conversion, produces no done pulse and clears the outputs.
- FSM states: IDLE, CONV_Q, CONV_R.
- Shift counter: 4 bits, counts 0..15 in each CONV state.
- IDLE:
  - start=1 at edge N captures dina, dinb, quot and rem.
  - Error check: err_cond = (dinb==0) or (dina==-32768 and dinb==-1).
  - If err_cond: stay in IDLE and at edge N pulse done=1, set err=1, q_bcd=r_bcd=0, q_neg=r_neg=0.
    - Correction: the pulse is registered, so done=1, err=1 and the cleared outputs appear at edge N+1. busy stays 0.
  - Otherwise:
    - q_neg <- quot[15]; load |quot| as a 16-bit unsigned magnitude (-32768 gives 32768, no saturation).
    - Hold the |rem| magnitude and rem[15] internally.
    - busy <- 1, counter <- 0, next state CONV_Q.
- CONV_Q (edges N+1..N+16):
  - Each edge: every BCD nibble >=5 gets +3, then {bcd, mag} shifts left one bit.
  - After the 16th shift, load the |rem| magnitude, clear the BCD accumulator and go to CONV_R.
  - The quotient BCD is held in an internal register. Outputs are not touched until done.
- CONV_R (edges N+17..N+32): same algorithm as CONV_Q.
  - At edge N+32, q_bcd, r_bcd, q_neg, r_neg are loaded from the final values (the last shift result, taken combinationally).
  - err <- 0, done <- 1, busy <- 0, next state IDLE.
- Latency: fixed 32 cycles from the start edge to the done edge. This is independent of operand values.
- Sign rules:
  - neg = operand bit 15.
  - A zero value always gives neg=0.
  - The remainder sign follows the dividend (truncating division). This block trusts its input and does not recheck it.
- start while busy=1: ignored, with no queueing. start in the same cycle as done=1 (busy=0) is accepted.
- Output hold: outputs keep their last values between done pulses. done is high for exactly one cycle.
- Width rules:
  - The magnitude path is 16-bit unsigned.
  - The BCD accumulator is 20 bits. No overflow is possible for magnitudes up to 32768.
  - Digit 4 never exceeds 3.

Test Plan:
- dina=100, dinb=7, quot=14, rem=2, start at edge N -> busy 1 for N..N+31. done at N+32 with q_bcd=20'h00014, r_bcd=20'h00002, q_neg=r_neg=0, err=0.
- quot=-7/2 case (dina=-7, dinb=2, quot=-3, rem=-1) -> q_neg=1, q_bcd=20'h00003, r_neg=1, r_bcd=20'h00001.
- dina=-32768, dinb=1, quot=-32768, rem=0 -> q_neg=1, q_bcd=20'h32768, r_bcd=0, r_neg=0, err=0.
- dinb=0, start at edge N -> done=1 and err=1 at edge N+1, all BCD and sign outputs 0, busy never 1.
  - Repeat with dina=-32768, dinb=-1: same response.
- Start with 12345/1 (quot=12345, rem=0), then pulse start again at N+5 with different operands -> second start ignored; done at N+32 with q_bcd=20'h12345.
  - A start asserted in the done cycle is accepted and produces a new done 32 cycles later.
- Start a conversion, assert rst at edge N+10 -> busy=0, outputs 0 from N+10. No done pulse follows.
  - A fresh start after reset completes normally.

Source files
------------

// File: rtl/div_result_bcd.sv
// div_result_bcd
// Downstream stage of the signed 16-bit divider. On a start strobe it
// captures the quotient/remainder pair, flags divide-by-zero and overflow,
// and converts each value to a sign bit plus five packed BCD digits. The
// conversion uses shift-add-3 (double dabble), one bit per clock.
//
// Ports:
//   clk    rising-edge system clock
//   rst    synchronous active-high reset
//   start  capture request, sampled only while busy=0
//   dina   signed dividend given to the divider (overflow check)
//   dinb   signed divisor given to the divider (zero/overflow check)
//   quot   signed quotient from the divider
//   rem    signed remainder from the divider
//   busy   conversion in progress
//   done   one-cycle pulse; result outputs update on the same edge
//   err    last result invalid (divide-by-zero or overflow)
//   q_neg  quotient sign
//   q_bcd  quotient magnitude, digit 4 in [19:16] down to digit 0 in [3:0]
//   r_neg  remainder sign
//   r_bcd  remainder magnitude, same digit layout as q_bcd
module div_result_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      dina,
  input  logic [WIDTH-1:0]      dinb,
  input  logic [WIDTH-1:0]      quot,
  input  logic [WIDTH-1:0]      rem,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  q_neg,
  output logic [4*DIGITS-1:0]   q_bcd,
  output logic                  r_neg,
  output logic [4*DIGITS-1:0]   r_bcd
);

  typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic [WIDTH-1:0]    mag;
  logic [4*DIGITS-1:0] bcd;
  logic [WIDTH-1:0]    r_mag_h;
  logic                q_neg_h;
  logic                r_neg_h;
  logic [4*DIGITS-1:0] q_hold;
  logic                err_pend;

  logic                err_cond;
  logic                last_shift;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] bcd_sh;
  logic [WIDTH-1:0]    mag_sh;

  // Two's-complement magnitude; -32768 maps to 32768 without saturation.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  assign err_cond   = (dinb == '0) ||
                      ((dina == {1'b1, {(WIDTH-1){1'b0}}}) && (dinb == '1));
  assign last_shift = (cnt == 4'd15);
  assign busy       = (state != IDLE);

  // One double-dabble step: add 3 to every nibble >= 5, then shift
  // {bcd, mag} left by one bit.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_sh = {bcd_adj[4*DIGITS-2:0], mag[WIDTH-1]};
    mag_sh = {mag[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !err_cond) state_nxt = CONV_Q;
      CONV_Q:  if (last_shift)         state_nxt = CONV_R;
      CONV_R:  if (last_shift)         state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mag      <= '0;
      bcd      <= '0;
      r_mag_h  <= '0;
      q_neg_h  <= 1'b0;
      r_neg_h  <= 1'b0;
      q_hold   <= '0;
      err_pend <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      q_neg    <= 1'b0;
      q_bcd    <= '0;
      r_neg    <= 1'b0;
      r_bcd    <= '0;
    end else begin
      state    <= state_nxt;
      done     <= 1'b0;
      err_pend <= 1'b0;

      // Error results are reported one edge after capture.
      if (err_pend) begin
        done  <= 1'b1;
        err   <= 1'b1;
        q_neg <= 1'b0;
        q_bcd <= '0;
        r_neg <= 1'b0;
        r_bcd <= '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (err_cond) begin
              err_pend <= 1'b1;
            end else begin
              mag     <= mag_of(quot);
              bcd     <= '0;
              r_mag_h <= mag_of(rem);
              q_neg_h <= quot[WIDTH-1];
              r_neg_h <= rem[WIDTH-1];
              cnt     <= '0;
            end
          end
        end
        CONV_Q: begin
          cnt <= cnt + 4'd1;
          if (last_shift) begin
            q_hold <= bcd_sh;
            mag    <= r_mag_h;
            bcd    <= '0;
          end else begin
            mag <= mag_sh;
            bcd <= bcd_sh;
          end
        end
        CONV_R: begin
          cnt <= cnt + 4'd1;
          mag <= mag_sh;
          bcd <= bcd_sh;
          if (last_shift) begin
            q_bcd <= q_hold;
            r_bcd <= bcd_sh;
            q_neg <= q_neg_h;
            r_neg <= r_neg_h;
            err   <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
module tb_div_result_bcd;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] dina, dinb, quot, rem;
  logic        busy, done, err, q_neg, r_neg;
  logic [19:0] q_bcd, r_bcd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        err;
    logic        qn;
    logic [19:0] qb;
    logic        rn;
    logic [19:0] rb;
    int          at;
  } exp_t;

  exp_t sb[$];

  div_result_bcd #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .dina(dina), .dinb(dinb),
    .quot(quot), .rem(rem), .busy(busy), .done(done), .err(err),
    .q_neg(q_neg), .q_bcd(q_bcd), .r_neg(r_neg), .r_bcd(r_bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("err", {31'd0, err}, {31'd0, e.err});
        chk("q_neg", {31'd0, q_neg}, {31'd0, e.qn});
        chk("q_bcd", {12'd0, q_bcd}, {12'd0, e.qb});
        chk("r_neg", {31'd0, r_neg}, {31'd0, e.rn});
        chk("r_bcd", {12'd0, r_bcd}, {12'd0, e.rb});
      end
    end
  end

  // Drives start for one cycle; n is the edge that samples it.
  task automatic issue(input logic [15:0] a, b, q, r, input logic e_err,
                       input logic qn, input logic [19:0] qb,
                       input logic rn, input logic [19:0] rb, output int n);
    exp_t e;
    @(negedge clk);
    dina = a; dinb = b; quot = q; rem = r; start = 1'b1;
    n = cyc + 1;
    e.err = e_err; e.qn = qn; e.qb = qb; e.rn = rn; e.rb = rb;
    e.at = e_err ? n + 1 : n + 32;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("timeout_done", 32'd1, 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n, k;
    logic saw_busy;
    rst = 1'b1; start = 1'b0; dina = '0; dinb = '0; quot = '0; rem = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_outs", {done, err, q_neg, r_neg, q_bcd, r_bcd}, 32'd0);
    rst = 1'b0;

    // 100 / 7 = 14 r 2; busy must be high N..N+31
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 20'h00014, 1'b0, 20'h00002, n);
    saw_busy = 1'b1;
    while (cyc < n + 32) begin
      if (!busy) saw_busy = 1'b0;
      @(negedge clk);
    end
    chk("busy_window", {31'd0, saw_busy}, 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
    wait_empty();

    // -7 / 2 = -3 r -1
    issue(-16'sd7, 16'd2, -16'sd3, -16'sd1, 1'b0, 1'b1, 20'h00003, 1'b1, 20'h00001, n);
    wait_empty();

    // -32768 / 1
    issue(16'h8000, 16'd1, 16'h8000, 16'd0, 1'b0, 1'b1, 20'h32768, 1'b0, 20'h00000, n);
    wait_empty();

    // Divide by zero: done+err at N+1, busy never 1
    issue(16'd55, 16'd0, 16'd9, 16'd9, 1'b1, 1'b0, 20'h0, 1'b0, 20'h0, n);
    saw_busy = 1'b0;
    repeat (3) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    chk("dz_busy", {31'd0, saw_busy}, 32'd0);
    wait_empty();

    // Valid result first so the overflow clears visible state
    issue(16'd9, 16'd1, 16'd9, 16'd0, 1'b0, 1'b0, 20'h00009, 1'b0, 20'h0, n);
    wait_empty();
    issue(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b1, 1'b0, 20'h0, 1'b0, 20'h0, n);
    wait_empty();

    // 12345 / 1, second start at N+5 ignored, start in done cycle accepted
    issue(16'd12345, 16'd1, 16'd12345, 16'd0, 1'b0, 1'b0, 20'h12345, 1'b0, 20'h0, n);
    while (cyc < n + 4) @(negedge clk);
    dina = 16'd50; dinb = 16'd3; quot = 16'd16; rem = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    begin
      exp_t e;
      dina = -16'sd1643; dinb = 16'd8; quot = -16'sd205; rem = -16'sd3; start = 1'b1;
      e.err = 1'b0; e.qn = 1'b1; e.qb = 20'h00205; e.rn = 1'b1; e.rb = 20'h00003;
      e.at = cyc + 1 + 32;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
    end
    wait_empty();

    // Reset at N+10 abandons the conversion
    issue(16'd777, 16'd1, 16'd777, 16'd0, 1'b0, 1'b0, 20'h00777, 1'b0, 20'h0, n);
    while (cyc < n + 9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_outs", {done, err, q_neg, r_neg, q_bcd, r_bcd}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_quiet", {31'd0, busy}, 32'd0);

    // Fresh conversion after reset: 1234 / 10 = 123 r 4
    issue(16'd1234, 16'd10, 16'd123, 16'd4, 1'b0, 1'b0, 20'h00123, 1'b0, 20'h00004, n);
    wait_empty();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
